// File: rtl/marmot_wb_mailbox.sv
//------------------------------------------------------------------------------
// Module      : marmot_wb_mailbox
// Description : Wishbone-slave mailbox between the management SoC and the core.
//               Two DEPTH-entry word FIFOs (M2C, C2M), sticky OVF/UDF flags,
//               and a level interrupt.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module marmot_wb_mailbox #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        m2c_valid,
  output logic [31:0] m2c_data,
  input  logic        m2c_ready,
  input  logic        c2m_valid,
  input  logic [31:0] c2m_data,
  output logic        c2m_ready,
  output logic        irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Register offsets within the 16-byte window (word index adr[3:2])
  localparam logic [1:0] REG_M2CDATA = 2'd0;
  localparam logic [1:0] REG_C2MDATA = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_IRQ_EN  = 2'd3;

  logic [31:0]   m2c_mem_q [DEPTH];
  logic [31:0]   c2m_mem_q [DEPTH];
  logic [AW-1:0] m2c_wr_q, m2c_wr_d, m2c_rd_q, m2c_rd_d;
  logic [AW-1:0] c2m_wr_q, c2m_wr_d, c2m_rd_q, c2m_rd_d;
  logic [CW-1:0] m2c_cnt_q, m2c_cnt_d, c2m_cnt_q, c2m_cnt_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic [1:0]    irq_en_q, irq_en_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic          irq_q, irq_d;

  logic        w_accept, w_hit;
  logic [1:0]  w_reg;
  logic        w_m2c_full, w_m2c_empty, w_c2m_full, w_c2m_empty;
  logic        w_m2c_wr, w_m2c_push, w_m2c_pop;
  logic        w_c2m_rd, w_c2m_push, w_c2m_pop;
  logic        w_w1c;
  logic [31:0] w_status, w_rdata;

  // Byte lanes and the sub-word address bits play no role: every access is a full word
  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0]};

  assign w_accept    = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign w_hit       = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_reg       = wbs_adr_i[3:2];

  // Occupancy flags come from pre-edge counts, so same-cycle push/pop never rescue each other
  assign w_m2c_full  = (m2c_cnt_q == FULL_CNT);
  assign w_m2c_empty = (m2c_cnt_q == '0);
  assign w_c2m_full  = (c2m_cnt_q == FULL_CNT);
  assign w_c2m_empty = (c2m_cnt_q == '0);

  assign w_m2c_wr    = w_accept & w_hit & wbs_we_i & (w_reg == REG_M2CDATA);
  assign w_m2c_push  = w_m2c_wr & ~w_m2c_full;
  assign w_m2c_pop   = ~w_m2c_empty & m2c_ready;

  assign w_c2m_rd    = w_accept & w_hit & ~wbs_we_i & (w_reg == REG_C2MDATA);
  assign w_c2m_pop   = w_c2m_rd & ~w_c2m_empty;
  assign w_c2m_push  = c2m_valid & ~w_c2m_full;

  assign w_w1c       = w_accept & w_hit & wbs_we_i & (w_reg == REG_STATUS);

  assign w_status = {8'h00, 8'(c2m_cnt_q), 8'(m2c_cnt_q), 2'b00,
                     udf_q, ovf_q, w_c2m_empty, w_c2m_full, w_m2c_empty, w_m2c_full};

  // Read-data mux for a hit read; misses and writes return zero
  always_comb begin
    w_rdata = 32'h0;
    if (w_hit && !wbs_we_i) begin
      case (w_reg)
        REG_C2MDATA: w_rdata = w_c2m_empty ? 32'h0 : c2m_mem_q[c2m_rd_q];
        REG_STATUS:  w_rdata = w_status;
        REG_IRQ_EN:  w_rdata = {30'h0, irq_en_q};
        default:     w_rdata = 32'h0;
      endcase
    end
  end

  // Next-state for pointers, counts, flags, bus response and interrupt
  always_comb begin
    m2c_wr_d  = m2c_wr_q;
    m2c_rd_d  = m2c_rd_q;
    m2c_cnt_d = m2c_cnt_q;
    c2m_wr_d  = c2m_wr_q;
    c2m_rd_d  = c2m_rd_q;
    c2m_cnt_d = c2m_cnt_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    irq_en_d  = irq_en_q;

    if (w_m2c_push) m2c_wr_d = m2c_wr_q + AW'(1);
    if (w_m2c_pop)  m2c_rd_d = m2c_rd_q + AW'(1);
    case ({w_m2c_push, w_m2c_pop})
      2'b10:   m2c_cnt_d = m2c_cnt_q + CW'(1);
      2'b01:   m2c_cnt_d = m2c_cnt_q - CW'(1);
      default: m2c_cnt_d = m2c_cnt_q;
    endcase

    if (w_c2m_push) c2m_wr_d = c2m_wr_q + AW'(1);
    if (w_c2m_pop)  c2m_rd_d = c2m_rd_q + AW'(1);
    case ({w_c2m_push, w_c2m_pop})
      2'b10:   c2m_cnt_d = c2m_cnt_q + CW'(1);
      2'b01:   c2m_cnt_d = c2m_cnt_q - CW'(1);
      default: c2m_cnt_d = c2m_cnt_q;
    endcase

    // Clear first so a simultaneous set takes priority
    if (w_w1c && wbs_dat_i[4]) ovf_d = 1'b0;
    if (w_w1c && wbs_dat_i[5]) udf_d = 1'b0;
    if (w_m2c_wr && w_m2c_full)  ovf_d = 1'b1;
    if (w_c2m_rd && w_c2m_empty) udf_d = 1'b1;

    if (w_accept && w_hit && wbs_we_i && (w_reg == REG_IRQ_EN)) irq_en_d = wbs_dat_i[1:0];

    ack_d = w_accept;
    dat_d = (w_accept && !wbs_we_i) ? w_rdata : 32'h0;

    // Evaluated on registered state, so the interrupt follows its cause by one cycle
    irq_d = (irq_en_q[0] & ~w_c2m_empty) | (irq_en_q[1] & (ovf_q | udf_q));
  end

  // State registers; reset discards FIFO contents and any pending acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m2c_mem_q[i] <= 32'h0;
        c2m_mem_q[i] <= 32'h0;
      end
      m2c_wr_q  <= '0;
      m2c_rd_q  <= '0;
      m2c_cnt_q <= '0;
      c2m_wr_q  <= '0;
      c2m_rd_q  <= '0;
      c2m_cnt_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      irq_en_q  <= 2'b00;
      ack_q     <= 1'b0;
      dat_q     <= 32'h0;
      irq_q     <= 1'b0;
    end else begin
      if (w_m2c_push) m2c_mem_q[m2c_wr_q] <= wbs_dat_i;
      if (w_c2m_push) c2m_mem_q[c2m_wr_q] <= c2m_data;
      m2c_wr_q  <= m2c_wr_d;
      m2c_rd_q  <= m2c_rd_d;
      m2c_cnt_q <= m2c_cnt_d;
      c2m_wr_q  <= c2m_wr_d;
      c2m_rd_q  <= c2m_rd_d;
      c2m_cnt_q <= c2m_cnt_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      irq_en_q  <= irq_en_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      irq_q     <= irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign m2c_valid = ~w_m2c_empty;
  assign m2c_data  = w_m2c_empty ? 32'h0 : m2c_mem_q[m2c_rd_q];
  assign c2m_ready = ~w_c2m_full;
  assign irq_o     = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_marmot_wb_mailbox.sv
//------------------------------------------------------------------------------
// Module      : tb_marmot_wb_mailbox
// Description : Self-checking bench for marmot_wb_mailbox against a queue model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_marmot_wb_mailbox;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic        m2c_valid, m2c_ready = 1'b0;
  logic [31:0] m2c_data;
  logic        c2m_valid = 1'b0, c2m_ready;
  logic [31:0] c2m_data = 32'h0;
  logic        irq;

  int tests = 0;
  int fails = 0;

  // Reference model: plain queues and flags
  logic [31:0] mq[$];
  logic [31:0] cq[$];
  bit          ovf, udf;
  bit   [1:0]  ien;

  marmot_wb_mailbox #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .m2c_valid(m2c_valid), .m2c_data(m2c_data), .m2c_ready(m2c_ready),
    .c2m_valid(c2m_valid), .c2m_data(c2m_data), .c2m_ready(c2m_ready),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    return {8'h00, 8'(cq.size()), 8'(mq.size()), 2'b00, udf, ovf,
            cq.size() == 0, cq.size() == DEPTH, mq.size() == 0, mq.size() == DEPTH};
  endfunction

  function automatic logic model_irq();
    return (ien[0] && cq.size() != 0) || (ien[1] && (ovf || udf));
  endfunction

  function automatic void model_reset();
    mq.delete(); cq.delete(); ovf = 0; udf = 0; ien = 2'b00;
  endfunction

  // Single Wishbone access; called just after a falling edge, returns after one too
  task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d, input string tag);
    logic [31:0] exp;
    exp = 32'h0;
    if (a[31:4] == BASE[31:4]) begin
      case (a[3:2])
        2'd0: if (w) begin
                if (mq.size() < DEPTH) mq.push_back(d); else ovf = 1;
              end
        2'd1: if (!w) begin
                if (cq.size() > 0) exp = cq.pop_front(); else udf = 1;
              end
        2'd2: if (!w) exp = model_status();
              else begin
                if (d[4]) ovf = 0;
                if (d[5]) udf = 0;
              end
        default: if (w) ien = d[1:0]; else exp = {30'h0, ien};
      endcase
    end
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
    @(negedge clk);
    chk({tag, "_ack"}, {31'h0, ack}, 32'h1);
    chk(tag, rdat, exp);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    chk({tag, "_ackdrop"}, {31'h0, ack}, 32'h0);
  endtask

  task automatic core_push(input logic [31:0] d);
    chk("c2m_ready", {31'h0, c2m_ready}, {31'h0, cq.size() < DEPTH});
    if (cq.size() < DEPTH) cq.push_back(d);
    c2m_valid = 1'b1; c2m_data = d;
    @(negedge clk);
    c2m_valid = 1'b0;
  endtask

  task automatic core_pop();
    chk("m2c_valid", {31'h0, m2c_valid}, {31'h0, mq.size() != 0});
    chk("m2c_data", m2c_data, (mq.size() != 0) ? mq.pop_front() : 32'h0);
    m2c_ready = 1'b1;
    @(negedge clk);
    m2c_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int op;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_m2c_valid", {31'h0, m2c_valid}, 32'h0);
    chk("rst_c2m_ready", {31'h0, c2m_ready}, 32'h1);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    v = model_status();
    chk("rst_status_model", v, 32'h0000_000A);
    wb(0, BASE + 32'h8, 0, "rst_status");

    // M2C fill past full, then drain through the core port
    for (int i = 1; i <= 5; i++) wb(1, BASE, 32'h11 * i, "m2c_wr");
    wb(0, BASE + 32'h8, 0, "m2c_full_status");
    for (int i = 0; i < 4; i++) core_pop();
    chk("m2c_empty_valid", {31'h0, m2c_valid}, 32'h0);
    wb(1, BASE + 32'h8, 32'h10, "w1c_ovf");

    // C2M fill, overdrain, then W1C both flags
    for (int i = 0; i < 4; i++) core_push(32'hA0 + i);
    chk("c2m_full_ready", {31'h0, c2m_ready}, 32'h0);
    for (int i = 0; i < 5; i++) wb(0, BASE + 32'h4, 0, "c2m_rd");
    wb(0, BASE + 32'h8, 0, "udf_status");
    wb(1, BASE + 32'h8, 32'h30, "w1c_both");
    wb(0, BASE + 32'h8, 0, "cleared_status");

    // Interrupt on C2M not empty
    wb(1, BASE + 32'hC, 32'h1, "ien_wr");
    wb(0, BASE + 32'hC, 0, "ien_rd");
    core_push(32'hBEEF);
    @(negedge clk);
    chk("irq_rise", {31'h0, irq}, 32'h1);
    wb(0, BASE + 32'h4, 0, "irq_pop");
    chk("irq_fall", {31'h0, irq}, 32'h0);
    wb(1, BASE + 32'hC, 32'h0, "ien_off");

    // WB pop of a full C2M while the core holds a word
    for (int i = 0; i < 4; i++) core_push(32'hC0 + i);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h4;
    c2m_valid = 1'b1; c2m_data = 32'h5A5A;
    @(negedge clk);
    chk("same_ack", {31'h0, ack}, 32'h1);
    chk("same_rd", rdat, cq.pop_front());
    chk("same_ready", {31'h0, c2m_ready}, 32'h1);
    stb = 1'b0; cyc = 1'b0;
    cq.push_back(32'h5A5A);
    @(negedge clk);
    c2m_valid = 1'b0;
    chk("same_refull", {31'h0, c2m_ready}, 32'h0);
    for (int i = 0; i < 4; i++) wb(0, BASE + 32'h4, 0, "same_drain");

    // Address outside the window
    wb(1, BASE + 32'h10, 32'h1234_5678, "miss_wr");
    wb(0, BASE + 32'h10, 0, "miss_rd");
    wb(0, BASE + 32'h8, 0, "miss_status");

    // Randomized mix against the model
    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 7));
      v  = $urandom;
      case (op)
        0, 1: wb(1, BASE | 32'($urandom_range(0, 3)), v, "r_m2c_wr");
        2:    wb(0, BASE + 32'h4 + 32'($urandom_range(0, 3)), 0, "r_c2m_rd");
        3:    core_pop();
        4, 5: core_push(v);
        6:    wb(0, BASE + 32'h8, 0, "r_status");
        default: begin
          if (v[0]) wb(1, BASE + 32'h8, v & 32'hFFFF_FFCF | {26'h0, v[9:8], 4'h0}, "r_w1c");
          else      wb(1, BASE + 32'hC, v, "r_ien");
        end
      endcase
      @(negedge clk);
      chk("r_irq", {31'h0, irq}, {31'h0, model_irq()});
      chk("r_m2c_valid", {31'h0, m2c_valid}, {31'h0, mq.size() != 0});
      chk("r_m2c_data", m2c_data, (mq.size() != 0) ? mq[0] : 32'h0);
      chk("r_c2m_ready", {31'h0, c2m_ready}, {31'h0, cq.size() < DEPTH});
    end

    // Reset asserted while an access is pending
    wb(1, BASE, 32'hDEAD, "pre_rst_wr");
    core_push(32'hFACE);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE; wdat = 32'h77;
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_mid_ack0", {31'h0, ack}, 32'h0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack1", {31'h0, ack}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ack2", {31'h0, ack}, 32'h0);
    chk("rst_mid_valid", {31'h0, m2c_valid}, 32'h0);
    wb(0, BASE + 32'h8, 0, "rst_mid_status");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
